// File: rtl/manycore_reset_timer.sv
// Reset-release and global timebase: delays tag-programming-done into the host reset,
// runs a free-running cycle counter from that reset and timestamps statistic requests.
module manycore_reset_timer #(
    parameter int width_p       = 32,
    parameter int reset_depth_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tag_done_i,
    input  logic               stat_v_i,
    input  logic [width_p-1:0] stat_tag_i,
    output logic               reset_o,
    output logic [width_p-1:0] ctr_r_o,
    output logic               stat_v_o,
    output logic [width_p-1:0] stat_tag_o,
    output logic [width_p-1:0] stat_ctr_o
);

    logic [reset_depth_p-1:0] chain_r;

    // Stage 0 holds the inverted done level; the last stage is the delayed reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chain_r <= '1;
        end else begin
            chain_r[0] <= ~tag_done_i;
            for (int i = 1; i < reset_depth_p; i++) begin
                chain_r[i] <= chain_r[i-1];
            end
        end
    end

    assign reset_o = chain_r[reset_depth_p-1];

    // Wraps silently at 2^width_p.
    always_ff @(posedge clk_i) begin
        if (reset_i || reset_o) begin
            ctr_r_o <= '0;
        end else begin
            ctr_r_o <= ctr_r_o + width_p'(1);
        end
    end

    // Captured tag/count hold across a re-asserted reset_o; only reset_i clears them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stat_v_o   <= 1'b0;
            stat_tag_o <= '0;
            stat_ctr_o <= '0;
        end else if (stat_v_i && !reset_o) begin
            stat_v_o   <= 1'b1;
            stat_tag_o <= stat_tag_i;
            stat_ctr_o <= ctr_r_o;
        end else begin
            stat_v_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_manycore_reset_timer.sv
// Bench for manycore_reset_timer: a 16-bit instance for the main checks and an 8-bit
// instance sharing the same stimulus for counter wrap.
module tb_manycore_reset_timer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        tag_done_i;
    logic        stat_v_i;
    logic [15:0] stat_tag_i;

    logic        reset_o;
    logic [15:0] ctr_r_o;
    logic        stat_v_o;
    logic [15:0] stat_tag_o;
    logic [15:0] stat_ctr_o;

    logic        reset8;
    logic [7:0]  ctr8;
    logic        stat_v8;
    logic [7:0]  stat_tag8;
    logic [7:0]  stat_ctr8;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_ctr = '0;
    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    manycore_reset_timer #(.width_p(16), .reset_depth_p(3)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .tag_done_i(tag_done_i),
        .stat_v_i(stat_v_i), .stat_tag_i(stat_tag_i),
        .reset_o(reset_o), .ctr_r_o(ctr_r_o), .stat_v_o(stat_v_o),
        .stat_tag_o(stat_tag_o), .stat_ctr_o(stat_ctr_o)
    );

    manycore_reset_timer #(.width_p(8), .reset_depth_p(3)) dut8 (
        .clk_i(clk_i), .reset_i(reset_i), .tag_done_i(tag_done_i),
        .stat_v_i(stat_v_i), .stat_tag_i(stat_tag_i[7:0]),
        .reset_o(reset8), .ctr_r_o(ctr8), .stat_v_o(stat_v8),
        .stat_tag_o(stat_tag8), .stat_ctr_o(stat_ctr8)
    );

    // Advance one edge and settle; the bench counter tracks expected count while running.
    task automatic tick();
        @(posedge clk_i);
        #1;
        m_ctr = m_ctr + 16'd1;
    endtask

    // Raise tag_done and step through the three-stage release; m_ctr restarts at 0.
    task automatic release_wait();
        tag_done_i = 1'b1;
        tick(); tick(); tick();
        m_ctr = '0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tag_done_i = 1'b1; stat_v_i = 1'b0; stat_tag_i = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (reset_o !== 1'b1 || ctr_r_o !== 16'd0 || stat_v_o !== 1'b0 ||
                stat_tag_o !== 16'd0 || stat_ctr_o !== 16'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got rst=%b ctr=%0d sv=%b tag=%h sc=%0d exp rst=1 rest=0",
                         i, reset_o, ctr_r_o, stat_v_o, stat_tag_o, stat_ctr_o);
            end
        end
        reset_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (reset_o !== (k < 3) || ctr_r_o !== 16'd0) begin
                errors++;
                $display("FAIL release_latency edge=%0d got rst=%b ctr=%0d exp rst=%b ctr=0",
                         k, reset_o, ctr_r_o, (k < 3));
            end
        end
        m_ctr = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ctr_r_o !== m_ctr || reset_o !== 1'b0) begin
                errors++;
                $display("FAIL count_after_release got ctr=%0d rst=%b exp ctr=%0d rst=0",
                         ctr_r_o, reset_o, m_ctr);
            end
        end
    endtask

    task automatic test_stat_capture();
        while (m_ctr != 16'd41) tick();
        checks++;
        if (ctr_r_o !== 16'd41) begin
            errors++;
            $display("FAIL ctr_at_41 got %0d exp 41", ctr_r_o);
        end
        stat_v_i = 1'b1; stat_tag_i = 16'hCAFE;
        exp_q.push_back({16'hCAFE, 16'd41});
        tick();
        stat_v_i = 1'b0; stat_tag_i = 16'h0000;
        checks++;
        if (stat_v_o !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL stat_valid got %b exp 1", stat_v_o);
        end else begin
            logic [31:0] exp_v;
            exp_v = exp_q.pop_front();
            checks++;
            if ({stat_tag_o, stat_ctr_o} !== exp_v) begin
                errors++;
                $display("FAIL stat_capture got %h exp %h", {stat_tag_o, stat_ctr_o}, exp_v);
            end
        end
        checks++;
        if (stat_tag8 !== 8'hFE || stat_ctr8 !== 8'd41 || stat_v8 !== 1'b1) begin
            errors++;
            $display("FAIL stat_capture_w8 got v=%b tag=%h ctr=%0d exp v=1 tag=fe ctr=41",
                     stat_v8, stat_tag8, stat_ctr8);
        end
        tick();
        checks++;
        if (stat_v_o !== 1'b0 || stat_tag_o !== 16'hCAFE || stat_ctr_o !== 16'd41) begin
            errors++;
            $display("FAIL stat_hold got v=%b tag=%h ctr=%0d exp v=0 tag=cafe ctr=41",
                     stat_v_o, stat_tag_o, stat_ctr_o);
        end
    endtask

    // Random strobes including back-to-back runs; each capture overwrites the last.
    task automatic test_back_to_back();
        logic [31:0] last_v;
        last_v = {16'hCAFE, 16'd41};
        for (int n = 0; n < 24; n++) begin
            if (n < 4 || $urandom_range(0, 1) == 1) begin
                stat_v_i   = 1'b1;
                stat_tag_i = 16'($urandom_range(0, 65535));
                exp_q.push_back({stat_tag_i, m_ctr});
            end else begin
                stat_v_i = 1'b0;
            end
            tick();
            stat_v_i = 1'b0;
            checks++;
            if (stat_v_o !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL b2b_valid n=%0d got %b exp %b", n, stat_v_o, (exp_q.size() != 0));
            end
            if (exp_q.size() != 0) last_v = exp_q.pop_front();
            checks++;
            if ({stat_tag_o, stat_ctr_o} !== last_v) begin
                errors++;
                $display("FAIL b2b_data n=%0d got %h exp %h", n, {stat_tag_o, stat_ctr_o}, last_v);
            end
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (ctr8 !== m_ctr[7:0] || ctr_r_o !== m_ctr || reset8 !== 1'b0) begin
                errors++;
                $display("FAIL count_wrap got c8=%0d c16=%0d r8=%b exp c8=%0d c16=%0d r8=0",
                         ctr8, ctr_r_o, reset8, m_ctr[7:0], m_ctr);
            end
        end
    endtask

    task automatic test_late_tag_done();
        reset_i = 1'b1; tag_done_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (reset_o !== 1'b1 || ctr_r_o !== 16'd0) begin
                errors++;
                $display("FAIL late_done_hold got rst=%b ctr=%0d exp rst=1 ctr=0", reset_o, ctr_r_o);
            end
        end
        tag_done_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (reset_o !== (k < 3) || ctr_r_o !== ((k == 4) ? 16'd1 : 16'd0)) begin
                errors++;
                $display("FAIL late_done_release edge=%0d got rst=%b ctr=%0d", k, reset_o, ctr_r_o);
            end
        end
        m_ctr = 16'd1;
    endtask

    // Dropping tag_done re-asserts reset_o; strobes during it are ignored, captures hold.
    task automatic test_tag_done_drop();
        logic [31:0] held;
        stat_v_i = 1'b1; stat_tag_i = 16'h5A5A;
        held = {16'h5A5A, m_ctr};
        tick();
        stat_v_i = 1'b0;
        tag_done_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (reset_o !== (k >= 3)) begin
                errors++;
                $display("FAIL drop_reassert edge=%0d got rst=%b exp %b", k, reset_o, (k >= 3));
            end
        end
        checks++;
        if (ctr_r_o !== 16'd0 || {stat_tag_o, stat_ctr_o} !== held) begin
            errors++;
            $display("FAIL drop_state got ctr=%0d stat=%h exp ctr=0 stat=%h",
                     ctr_r_o, {stat_tag_o, stat_ctr_o}, held);
        end
        stat_v_i = 1'b1; stat_tag_i = 16'h1234;
        tick();
        stat_v_i = 1'b0;
        tick();
        checks++;
        if (stat_v_o !== 1'b0 || {stat_tag_o, stat_ctr_o} !== held) begin
            errors++;
            $display("FAIL stat_in_reset got v=%b stat=%h exp v=0 stat=%h",
                     stat_v_o, {stat_tag_o, stat_ctr_o}, held);
        end
    endtask

    task automatic test_pulse_and_glitch();
        @(posedge clk_i);
        #3 tag_done_i = 1'b1;
        #2 tag_done_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (reset_o !== 1'b1) begin
                errors++;
                $display("FAIL glitch got rst=%b exp 1", reset_o);
            end
        end
        tag_done_i = 1'b1;
        tick();
        tag_done_i = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            tick();
            checks++;
            if (reset_o !== (k != 3)) begin
                errors++;
                $display("FAIL pulse_window edge=%0d got rst=%b exp %b", k, reset_o, (k != 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        release_wait();
        while (m_ctr != 16'd100) tick();
        checks++;
        if (ctr_r_o !== 16'd100) begin
            errors++;
            $display("FAIL ctr_at_100 got %0d exp 100", ctr_r_o);
        end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++;
        if (reset_o !== 1'b1 || ctr_r_o !== 16'd0 || stat_v_o !== 1'b0 ||
            stat_tag_o !== 16'd0 || stat_ctr_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got rst=%b ctr=%0d sv=%b tag=%h sc=%0d exp rst=1 rest=0",
                     reset_o, ctr_r_o, stat_v_o, stat_tag_o, stat_ctr_o);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (reset_o !== (k < 3) || ctr_r_o !== ((k <= 3) ? 16'd0 : 16'(k - 3))) begin
                errors++;
                $display("FAIL mid_reset_release edge=%0d got rst=%b ctr=%0d", k, reset_o, ctr_r_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stat_capture();
        test_back_to_back();
        test_count_wrap();
        test_late_tag_done();
        test_tag_done_drop();
        test_pulse_and_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
